// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg
// Shared constants for the ID-stage hazard controller: RV32I major opcodes,
// the FSM state encoding and small opcode-classification helpers.
// No ports.
package hazard_control_unit_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1
  } hcu_state_e;

  // rs1 is a real operand for every format except U-type and JAL.
  function automatic logic rs1_used(input logic [6:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  // rs2 is only read by R-type, stores and branches.
  function automatic logic rs2_used(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

  // Instructions whose operands are consumed in ID (branch comparator / JALR adder).
  function automatic logic resolves_in_id(input logic [6:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if
// Bundles the ID-stage view used by the hazard controller.
//   master : pipeline side, drives instruction/pipeline info, reads controls
//   slave  : hazard controller, reads pipeline info, drives controls
// There is no handshake here: every signal is a level valid for the current
// cycle only, sampled combinationally; no valid/ready pair is involved.
interface hazard_control_unit_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [6:0]                IF_ID_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic                      ID_EX_mem_rd_en;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      EX_MEM_mem_rd_en;
  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd;
  logic                      branch_taken;
  logic                      ext_stall;

  logic                      pc_wr_en;
  logic                      IF_ID_wr_en;
  logic                      IF_ID_flush;
  logic                      ID_EX_flush;
  logic                      pc_redirect;
  logic                      stall;

  modport master (
    output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, ext_stall,
    input  pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, pc_redirect, stall
  );

  modport slave (
    input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, ext_stall,
    output pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, pc_redirect, stall
  );

endinterface

// File: rtl/hazard_control_unit_hazard_detect.sv
// hazard_detect
// Purely combinational dependency checks between the instruction in ID and
// loads in EX / MEM.
//   opcode, rs1, rs2   : ID instruction
//   ex_ld, ex_rd       : EX holds a load writing ex_rd
//   mem_ld, mem_rd     : MEM holds a load writing mem_rd
//   load_use           : ID reads the EX load's result
//   br_ld_ex           : ID branch/JALR reads the EX load's result
//   br_ld_mem          : ID branch/JALR reads the MEM load's result
module hazard_detect
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [6:0]                opcode,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      ex_ld,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_ld,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      load_use,
  output logic                      br_ld_ex,
  output logic                      br_ld_mem
);

  logic use1;
  logic use2;
  logic early;
  logic ex_match;
  logic mem_match;

  assign use1  = rs1_used(opcode);
  assign use2  = rs2_used(opcode);
  assign early = resolves_in_id(opcode);

  // x0 is hard-wired, so a load targeting it never creates a dependency.
  assign ex_match  = (ex_rd != '0) &&
                     ((use1 && (rs1 == ex_rd)) || (use2 && (rs2 == ex_rd)));
  assign mem_match = (mem_rd != '0) &&
                     ((use1 && (rs1 == mem_rd)) || (use2 && (rs2 == mem_rd)));

  assign load_use  = ex_ld && ex_match;
  assign br_ld_ex  = early && load_use;
  assign br_ld_mem = early && mem_ld && mem_match;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// ID-stage hazard controller: load-use stalls, branch-after-load stalls
// (two bubbles when the load is in EX, sequenced by a RUN/BR_WAIT FSM) and
// wrong-path squash on taken branches / jumps resolved in ID.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   hz (slave)      : pipeline inputs and control outputs
//   fsm_state       : current FSM state (debug)
//   stall_cycle_cnt : saturating count of hazard stall cycles
//                     (present only when HAZARD_STALL_CNT_EN is defined)
// Build option: HAZARD_STALL_CNT_EN adds the stall cycle counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hz,
  output logic [1:0]           fsm_state
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycle_cnt
`endif
);

  hcu_state_e state;
  logic       load_use;
  logic       br_ld_ex;
  logic       br_ld_mem;
  logic       hazard;
  logic       redirect_req;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_detect (
    .opcode    (hz.IF_ID_inst_opcode),
    .rs1       (hz.IF_ID_rs1),
    .rs2       (hz.IF_ID_rs2),
    .ex_ld     (hz.ID_EX_mem_rd_en),
    .ex_rd     (hz.ID_EX_rd),
    .mem_ld    (hz.EX_MEM_mem_rd_en),
    .mem_rd    (hz.EX_MEM_rd),
    .load_use  (load_use),
    .br_ld_ex  (br_ld_ex),
    .br_ld_mem (br_ld_mem)
  );

  // Internal stall decision; BR_WAIT supplies the second bubble of a
  // branch that depended on a load in EX.
  always_comb begin
    hazard = 1'b0;
    case (state)
      ST_RUN:     hazard = load_use | br_ld_mem;  // br_ld_ex implies load_use
      ST_BR_WAIT: hazard = 1'b1;
      default:    hazard = 1'b0;
    endcase
  end

  assign redirect_req = ((hz.IF_ID_inst_opcode == OPC_BRANCH) && hz.branch_taken) ||
                        (hz.IF_ID_inst_opcode == OPC_JAL) ||
                        (hz.IF_ID_inst_opcode == OPC_JALR);

  always_comb begin
    hz.pc_wr_en    = 1'b1;
    hz.IF_ID_wr_en = 1'b1;
    hz.IF_ID_flush = 1'b0;
    hz.ID_EX_flush = 1'b0;
    hz.pc_redirect = 1'b0;
    hz.stall       = hazard;
    if (rst) begin
      hz.pc_wr_en    = 1'b0;
      hz.IF_ID_wr_en = 1'b0;
      hz.IF_ID_flush = 1'b1;
      hz.ID_EX_flush = 1'b1;
      hz.stall       = 1'b0;
    end else if (hz.ext_stall) begin
      // Global freeze: nothing moves, no bubble; stall still reports the hazard.
      hz.pc_wr_en    = 1'b0;
      hz.IF_ID_wr_en = 1'b0;
    end else if (hazard) begin
      // A stalled branch must not redirect on a comparator fed by stale data.
      hz.pc_wr_en    = 1'b0;
      hz.IF_ID_wr_en = 1'b0;
      hz.ID_EX_flush = 1'b1;
    end else if (redirect_req) begin
      hz.pc_redirect = 1'b1;
      hz.IF_ID_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (!hz.ext_stall) begin
      case (state)
        ST_RUN:     if (br_ld_ex) state <= ST_BR_WAIT;
        ST_BR_WAIT: state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  assign fsm_state = state;

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycle_cnt <= '0;
    end else if (hazard && !hz.ext_stall && (stall_cycle_cnt != 32'hFFFF_FFFF)) begin
      stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
